gates_checker: RTL

//  Synthesizable stimulus/response engine for the 2-input gates block (x=AND, y=XOR, z=OR).

---
 rtl/gates_pkg.sv | 8 +
 rtl/gates_golden.sv | 10 +
 rtl/gates_checker.sv | 91 +++++++++
 3 files changed

// File: rtl/gates_pkg.sv
// gates_pkg: shared state encoding, case count and golden gate function for gate checkers
package gates_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_e;
  localparam int NUM_CASES = 4;
  function automatic logic [2:0] gates_expect(input logic a, input logic b);
    return {a & b, a ^ b, a | b};
  endfunction
endpackage

// File: rtl/gates_golden.sv
// gates_golden: combinational reference {x,y,z} = {AND, XOR, OR} of a/b
module gates_golden
  import gates_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [2:0] xyz
);
  assign xyz = gates_expect(a, b);
endmodule

// File: rtl/gates_checker.sv
// gates_checker: drives all four a/b cases into the gates block and scores x/y/z against gates_golden
module gates_checker
  import gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             x_i,
  input  logic             y_i,
  input  logic             z_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_mask,
  output logic [1:0]       case_idx
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SW = (ERR_W > 2 ? ERR_W : 2) + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       case_q, case_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       mask_q, mask_d;
  logic [2:0]       exp_xyz, diff;
  logic [SW-1:0]    sum;
  gates_golden u_golden (.a(a_o), .b(b_o), .xyz(exp_xyz));
  assign diff = exp_xyz ^ {x_i, y_i, z_i};
  assign sum  = SW'(err_q) + SW'(diff[0]) + SW'(diff[1]) + SW'(diff[2]);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case_d  = case_q;
    err_d   = err_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SETTLE;
        cnt_d   = '0;
        case_d  = '0;
        err_d   = '0;
        mask_d  = '0;
      end
      SETTLE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        err_d          = (sum > SW'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
        mask_d[case_q] = mask_q[case_q] | (|diff);
        if (case_q == 2'(NUM_CASES - 1)) state_d = DONE;
        else begin
          state_d = SETTLE;
          case_d  = case_q + 2'd1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      case_q  <= '0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      case_q  <= case_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end
  // stimulus is the case counter itself, so a/b stay on case 3 through DONE
  assign a_o       = case_q[0];
  assign b_o       = case_q[1];
  assign case_idx  = case_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
endmodule
